// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: elastic pipeline stage register with a two-entry skid buffer.
//
// Carries an opaque WIDTH-bit payload between two pipeline stages over a
// valid/ready handshake. in_ready depends only on registered state, so a
// downstream stall reaches upstream one cycle later and never forms a
// combinational ready chain across stages. The skid register absorbs the
// one payload that arrives during that cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset (priority over flush/handshake)
//   flush      synchronous clear of all held entries (bubble insertion)
//   in_valid   upstream presents a payload
//   in_ready   this stage can accept a payload this cycle
//   in_data    upstream payload
//   out_valid  out_data holds a live payload
//   out_ready  downstream accepts out_data this cycle
//   out_data   payload to downstream (BUBBLE whenever out_valid = 0)
//   occupancy  number of held entries, 0..2
module pipe_skid_reg #(
  parameter int unsigned            WIDTH  = 32,
  parameter logic [WIDTH-1:0]       BUBBLE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // The state encoding equals the number of held entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             main_v, skid_v;
  logic             in_fire, out_fire;

  assign main_v    = (state != EMPTY);
  assign skid_v    = (state == FULL);

  assign in_ready  = ~skid_v;
  assign out_valid = main_v;
  assign out_data  = main_q;
  assign occupancy = state;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d = state;
    main_d  = main_q;
    skid_d  = skid_q;

    case (state)
      EMPTY: begin
        if (in_fire) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d  = in_data;
        end else if (in_fire) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (out_fire) begin
          // Rewriting main to BUBBLE keeps out_data correct without an output mux.
          state_d = EMPTY;
          main_d  = BUBBLE;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d = ONE;
          main_d  = skid_q;
          skid_d  = BUBBLE;
        end
      end
      default: begin
        state_d = EMPTY;
        main_d  = BUBBLE;
        skid_d  = BUBBLE;
      end
    endcase

    // Flush discards a same-cycle input fire; an output fire is already consumed.
    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      main_q <= BUBBLE;
      skid_q <= BUBBLE;
    end else begin
      state  <= state_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

endmodule
